fir_coef_loader: RTL

- Sequences coefficient downloads into the FIR filter bank's coefficient RAMs from a host byte stream (SPI register path).
- Quiesces the audio path, then for each filter RAM in turn:
  - pulses the shared write-address reset and checks it took;
  - assembles each 16-bit coefficient from MSB then LSB bytes;
  - issues spaced write strobes that respect the bank's registered select mux and its delayed address auto-increment.
- Restores audio enable on completion and reports done or error.

---
 rtl/fir_coef_loader.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fir_coef_loader.sv
// Coefficient download sequencer: streams host bytes into the FIR bank's coefficient RAMs,
// one filter at a time. Optional trailing checksum via FIR_COEF_LOADER_CHECKSUM_EN.
module fir_coef_loader #(
    parameter int taps_per_filter = 4,
    parameter int QUIESCE_CLKS    = 600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [8:0] coefs_per_tap,
    input  logic       audio_en_in,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       wr_addr_zero,
    output logic       audio_en,
    output logic       coef_addr_rst,
    output logic       coefficient_wr_en,
    output logic [5:0] coef_select,
    output logic [7:0] coef_wr_msb_data,
    output logic [7:0] coef_wr_lsb_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int QW = $clog2(QUIESCE_CLKS + 1);
    localparam logic [QW-1:0] Q_LAST  = QW'(QUIESCE_CLKS - 1);
    localparam logic [5:0]   LAST_SEL = 6'(taps_per_filter - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_QUIESCE, S_ARST, S_ACHK, S_MSB, S_LSB,
        S_WR, S_HOLD, S_NEXT, S_FIN, S_CSM, S_CSL
    } state_t;

    state_t        r_state, w_state_next;
    logic [QW-1:0] r_qcnt, w_qcnt_next;
    logic          r_sub, w_sub_next;
    logic [8:0]    r_count, w_count_next;
    logic [8:0]    r_cpt, w_cpt_next;
    logic [5:0]    r_select, w_select_next;
    logic [7:0]    r_msb, w_msb_next;
    logic [7:0]    r_lsb, w_lsb_next;
    logic          r_error, w_error_next;
    logic          r_audio_en, r_byte_ready, r_addr_rst, r_wr_en, r_busy, r_done;
    logic          w_hs;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
    logic [15:0]   r_sum, w_sum_next;
    logic [7:0]    r_chk_msb, w_chk_msb_next;
`endif

    assign w_hs = r_byte_ready & byte_valid;

    always_comb begin
        w_state_next  = r_state;
        w_qcnt_next   = r_qcnt;
        w_sub_next    = r_sub;
        w_count_next  = r_count;
        w_cpt_next    = r_cpt;
        w_select_next = r_select;
        w_msb_next    = r_msb;
        w_lsb_next    = r_lsb;
        w_error_next  = r_error;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
        w_sum_next     = r_sum;
        w_chk_msb_next = r_chk_msb;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (coefs_per_tap != 9'd0) begin
                        w_error_next  = 1'b0;
                        w_select_next = 6'd0;
                        w_cpt_next    = coefs_per_tap;
                        w_qcnt_next   = '0;
                        w_state_next  = S_QUIESCE;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
                        w_sum_next    = 16'd0;
`endif
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            S_QUIESCE: begin
                if (r_qcnt == Q_LAST) w_state_next = S_ARST;
                else                  w_qcnt_next  = r_qcnt + 1'b1;
            end
            S_ARST: begin
                w_sub_next   = 1'b0;
                w_state_next = S_ACHK;
            end
            S_ACHK: begin
                // First cycle lets the bank's address register settle after the reset pulse.
                if (!r_sub) begin
                    w_sub_next = 1'b1;
                end else if (wr_addr_zero) begin
                    w_count_next = 9'd0;
                    w_state_next = S_MSB;
                end else begin
                    w_error_next = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_MSB: begin
                if (w_hs) begin
                    w_msb_next   = byte_data;
                    w_state_next = S_LSB;
                end
            end
            S_LSB: begin
                if (w_hs) begin
                    w_lsb_next   = byte_data;
                    w_state_next = S_WR;
                end
            end
            S_WR: begin
                w_sub_next   = 1'b0;
                w_state_next = S_HOLD;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
                w_sum_next   = r_sum + {r_msb, r_lsb};
`endif
            end
            S_HOLD: begin
                // Data and select stay frozen until the bank's delayed address increment lands.
                if (!r_sub) begin
                    w_sub_next = 1'b1;
                end else begin
                    w_count_next = r_count + 9'd1;
                    if ((r_count + 9'd1) == r_cpt) w_state_next = S_NEXT;
                    else                           w_state_next = S_MSB;
                end
            end
            S_NEXT: begin
                if (r_select == LAST_SEL) begin
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
                    w_state_next = S_CSM;
`else
                    w_state_next = S_FIN;
`endif
                end else begin
                    w_select_next = r_select + 6'd1;
                    w_state_next  = S_ARST;
                end
            end
            S_FIN: w_state_next = S_IDLE;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            S_CSM: begin
                if (w_hs) begin
                    w_chk_msb_next = byte_data;
                    w_state_next   = S_CSL;
                end
            end
            S_CSL: begin
                if (w_hs) begin
                    if ({r_chk_msb, byte_data} == r_sum) begin
                        w_state_next = S_FIN;
                    end else begin
                        w_error_next = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
            w_error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_qcnt       <= '0;
            r_sub        <= 1'b0;
            r_count      <= 9'd0;
            r_cpt        <= 9'd0;
            r_select     <= 6'd0;
            r_msb        <= 8'd0;
            r_lsb        <= 8'd0;
            r_error      <= 1'b0;
            r_audio_en   <= 1'b0;
            r_byte_ready <= 1'b0;
            r_addr_rst   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            r_sum        <= 16'd0;
            r_chk_msb    <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_qcnt       <= w_qcnt_next;
            r_sub        <= w_sub_next;
            r_count      <= w_count_next;
            r_cpt        <= w_cpt_next;
            r_select     <= w_select_next;
            r_msb        <= w_msb_next;
            r_lsb        <= w_lsb_next;
            r_error      <= w_error_next;
            // Audio is cut the clock a load starts and comes back one clock after IDLE is re-entered.
            r_audio_en   <= (r_state == S_IDLE && w_state_next == S_IDLE) ? audio_en_in : 1'b0;
            r_byte_ready <= (w_state_next == S_MSB) || (w_state_next == S_LSB) ||
                            (w_state_next == S_CSM) || (w_state_next == S_CSL);
            r_addr_rst   <= (w_state_next == S_ARST);
            r_wr_en      <= (w_state_next == S_WR);
            r_busy       <= (w_state_next != S_IDLE);
            r_done       <= (w_state_next == S_FIN);
`ifdef FIR_COEF_LOADER_CHECKSUM_EN
            r_sum        <= w_sum_next;
            r_chk_msb    <= w_chk_msb_next;
`endif
        end
    end

    assign byte_ready        = r_byte_ready;
    assign audio_en          = r_audio_en;
    assign coef_addr_rst     = r_addr_rst;
    assign coefficient_wr_en = r_wr_en;
    assign coef_select       = r_select;
    assign coef_wr_msb_data  = r_msb;
    assign coef_wr_lsb_data  = r_lsb;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;

endmodule
